// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder/subtractor controller.
package serial_adder_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_adder_ctrl_if.sv
// Request/result handshake bundle between a requester and serial_adder_ctrl.
interface serial_adder_ctrl_if #(
  parameter int WIDTH = serial_adder_pkg::DEFAULT_WIDTH
);
  logic             start_valid;
  logic             start_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sub;
  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] sum;
  logic             carry_out;
  logic             overflow;
  logic             busy;

  modport master (
    output start_valid, a, b, sub, res_ready,
    input  start_ready, res_valid, sum, carry_out, overflow, busy
  );

  modport slave (
    input  start_valid, a, b, sub, res_ready,
    output start_ready, res_valid, sum, carry_out, overflow, busy
  );
endinterface

// File: rtl/full_adder.sv
// Single-bit full adder; the only arithmetic element of the serial datapath.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial add/subtract controller: one full adder, LSB first, WIDTH cycles per op.
//   state | meaning
//   IDLE  | ready for a new operation
//   RUN   | shifting one bit per cycle through the full adder
//   DONE  | result held until the consumer accepts it
module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input logic                clk,
  input logic                rst,
  serial_adder_ctrl_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] op_a_q, op_b_q, result_q;
  logic             carry_q, msb_carry_q;
  logic [CNT_W-1:0] cnt_q;
  logic             fa_s, fa_c;
  logic             accept, last_bit;

  full_adder u_fa (
    .a   (op_a_q[0]),
    .b   (op_b_q[0]),
    .cin (carry_q),
    .s   (fa_s),
    .cout(fa_c)
  );

  assign accept   = (state_q == IDLE) && bus.start_valid;
  assign last_bit = (cnt_q == LAST_BIT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start_valid) state_d = RUN;
      RUN:     if (last_bit) state_d = DONE;
      DONE:    if (bus.res_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Subtraction is a + ~b + 1: invert b on load and seed the carry with sub.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_a_q      <= '0;
      op_b_q      <= '0;
      result_q    <= '0;
      carry_q     <= 1'b0;
      msb_carry_q <= 1'b0;
      cnt_q       <= '0;
    end else if (accept) begin
      op_a_q   <= bus.a;
      op_b_q   <= bus.sub ? ~bus.b : bus.b;
      carry_q  <= bus.sub;
      cnt_q    <= '0;
      result_q <= '0;
    end else if (state_q == RUN) begin
      result_q <= {fa_s, result_q[WIDTH-1:1]};
      op_a_q   <= op_a_q >> 1;
      op_b_q   <= op_b_q >> 1;
      carry_q  <= fa_c;
      cnt_q    <= cnt_q + 1'b1;
      if (last_bit) msb_carry_q <= carry_q;
    end
  end

  always_comb begin
    bus.start_ready = (state_q == IDLE);
    bus.busy        = (state_q != IDLE);
    bus.res_valid   = (state_q == DONE);
    bus.sum         = '0;
    bus.carry_out   = 1'b0;
    bus.overflow    = 1'b0;
    if (state_q == DONE) begin
      bus.sum       = result_q;
      bus.carry_out = carry_q;
      bus.overflow  = msb_carry_q ^ carry_q;
    end
  end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Randomized and directed bench for serial_adder_ctrl against a cycle-level behavioural model.
module tb_serial_adder_ctrl;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  serial_adder_ctrl_if #(.WIDTH(W)) bus ();

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Reference: {overflow, carry_out, sum} from plain integer arithmetic.
  function automatic logic [9:0] ref_op(logic [7:0] x, logic [7:0] y, logic s);
    int ux, uy, sx, sy, r, rs;
    logic c;
    ux = int'(x);
    uy = int'(y);
    sx = int'($signed(x));
    sy = int'($signed(y));
    if (s) begin
      r  = ux - uy;
      c  = (ux >= uy);
      rs = sx - sy;
    end else begin
      r  = ux + uy;
      c  = (r > 255);
      rs = sx + sy;
    end
    return {(rs > 127) || (rs < -128), c, r[7:0]};
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: busy for W run cycles plus the done phase, result known at accept.
  logic       m_busy, m_done;
  int         m_left;
  logic [7:0] m_sum;
  logic       m_c, m_ov;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy <= 1'b0;
      m_done <= 1'b0;
      m_left <= 0;
      m_sum  <= '0;
      m_c    <= 1'b0;
      m_ov   <= 1'b0;
    end else if (!m_busy) begin
      if (bus.start_valid) begin
        m_busy <= 1'b1;
        m_left <= W;
        {m_ov, m_c, m_sum} <= ref_op(bus.a, bus.b, bus.sub);
      end
    end else if (!m_done) begin
      if (m_left == 1) m_done <= 1'b1;
      m_left <= m_left - 1;
    end else if (bus.res_ready) begin
      m_busy <= 1'b0;
      m_done <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      check("start_ready", 32'(bus.start_ready), 32'(!m_busy));
      check("busy",        32'(bus.busy),        32'(m_busy));
      check("res_valid",   32'(bus.res_valid),   32'(m_done));
      check("sum",         32'(bus.sum),         m_done ? 32'(m_sum) : 32'd0);
      check("carry_out",   32'(bus.carry_out),   m_done ? 32'(m_c)   : 32'd0);
      check("overflow",    32'(bus.overflow),    m_done ? 32'(m_ov)  : 32'd0);
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (!bus.start_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!bus.start_ready) check("wait_idle_timeout", 32'd1, 32'd0);
  endtask

  // Presents an op at a negedge; returns at the negedge right after the accept edge.
  task automatic issue(logic [7:0] x, logic [7:0] y, logic s);
    wait_idle();
    bus.start_valid = 1'b1;
    bus.a = x;
    bus.b = y;
    bus.sub = s;
    @(negedge clk);
    bus.start_valid = 1'b0;
  endtask

  task automatic directed(string name, logic [7:0] x, logic [7:0] y, logic s,
                          logic [7:0] e_sum, logic e_c, logic e_ov, int hold);
    int edges = 1;
    bus.res_ready = 1'b0;
    issue(x, y, s);
    check({name, "_model_pin"}, 32'(ref_op(x, y, s)), 32'({e_ov, e_c, e_sum}));
    while (!bus.res_valid && edges < 40) begin
      @(negedge clk);
      edges++;
    end
    check({name, "_latency"}, 32'(edges), 32'(W + 1));
    check({name, "_sum"},     32'(bus.sum),       32'(e_sum));
    check({name, "_carry"},   32'(bus.carry_out), 32'(e_c));
    check({name, "_ovf"},     32'(bus.overflow),  32'(e_ov));
    for (int i = 0; i < hold; i++) begin
      bus.start_valid = 1'($urandom);
      bus.a = 8'($urandom);
      bus.b = 8'($urandom);
      bus.sub = 1'($urandom);
      @(negedge clk);
      check({name, "_hold_sum"},   32'(bus.sum),         32'(e_sum));
      check({name, "_hold_ready"}, 32'(bus.start_ready), 32'd0);
      check({name, "_hold_valid"}, 32'(bus.res_valid),   32'd1);
    end
    bus.start_valid = 1'b0;
    bus.res_ready = 1'b1;
    @(negedge clk);
    bus.res_ready = 1'b0;
    check({name, "_release"}, 32'(bus.start_ready), 32'd1);
  endtask

  initial begin
    bus.start_valid = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.sub = 1'b0;
    bus.res_ready = 1'b0;
    #12;
    check("rst_start_ready", 32'(bus.start_ready), 32'd1);
    check("rst_res_valid",   32'(bus.res_valid),   32'd0);
    check("rst_busy",        32'(bus.busy),        32'd0);
    check("rst_outs", 32'({bus.sum, bus.carry_out, bus.overflow}), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    directed("add_0f_01", 8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0, 0);
    directed("add_ff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 0);
    directed("add_7f_01", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 0);
    directed("sub_05_07", 8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 1'b0, 0);
    directed("sub_80_01", 8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1, 0);
    directed("backpress", 8'h3C, 8'h5A, 1'b0, 8'h96, 1'b0, 1'b1, 5);

    // Abort in RUN with counter at 3, then accept straight after release.
    issue(8'h33, 8'h44, 1'b0);
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort_start_ready", 32'(bus.start_ready), 32'd1);
    check("abort_busy",        32'(bus.busy),        32'd0);
    check("abort_res_valid",   32'(bus.res_valid),   32'd0);
    check("abort_outs", 32'({bus.sum, bus.carry_out, bus.overflow}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    directed("post_rst", 8'h01, 8'h02, 1'b0, 8'h03, 1'b0, 1'b0, 0);

    // Fully random traffic; the per-cycle compare process does the checking.
    for (int i = 0; i < 2000; i++) begin
      bus.start_valid = ($urandom_range(0, 2) != 0);
      bus.a = 8'($urandom);
      bus.b = 8'($urandom);
      bus.sub = 1'($urandom);
      bus.res_ready = ($urandom_range(0, 3) == 0);
      @(negedge clk);
    end
    bus.start_valid = 1'b0;
    bus.res_ready = 1'b1;
    repeat (W + 3) @(negedge clk);
    check("final_idle", 32'(bus.start_ready), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
